ctrl_seq: RTL and testbench
===========================

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, width of all address ports.
REQ-002 Parameter CALC_TIMEOUT, default 1024, max cycles allowed in CALC before abort.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  soft restart request from CPU.
REQ-006 coef_load_req  input  1  CPU requests coefficient pointer load.
REQ-007 sample_valid  input  1  upstream presents a new input sample.
REQ-008 sample_ready  output  1  sequencer accepts the sample this cycle.
REQ-009 data_lptr  input  ADDR_WIDTH  sample segment lower bound, inclusive.
REQ-010 data_bptr  input  ADDR_WIDTH  sample segment upper bound, inclusive; data_lptr <= data_bptr.
REQ-011 conv_pass  input  1  convolution finished flag from RAM driver.
REQ-012 data_hptr  output  ADDR_WIDTH  ring buffer head address.
REQ-013 sample_we  output  1  write strobe for the new sample at data_hptr.
REQ-014 en_init, ringbuf_init, en_calc, coeff_load, ringbuf_addr_clr  output  1 each  RAM driver controls.
REQ-015 conv_done  output  1  one-cycle pulse, result ready downstream.
REQ-016 timeout_err  output  1  sticky error flag, set on CALC timeout.

Function
REQ-017 FSM states: CLEAR, IDLE, LOAD, WRITE, INIT, CALC, DONE; all outputs are registered Moore decodes of state.
REQ-018 CLEAR: ringbuf_addr_clr=1, data_hptr<=data_lptr, calc counter<=0; next state IDLE.
REQ-019 IDLE: sample_ready = !coef_load_req; coef_load_req=1 -> LOAD; else sample_valid=1 -> WRITE.
REQ-020 Simultaneous coef_load_req and sample_valid: LOAD wins, the sample is not accepted, sample_ready=0 that cycle.
REQ-021 LOAD: coeff_load=1 for exactly one cycle -> IDLE.
REQ-022 WRITE: sample_we=1 for one cycle with data_hptr stable -> INIT.
REQ-023 INIT: en_init=1 and ringbuf_init=1 for one cycle -> CALC.
REQ-024 CALC: en_calc=1 each cycle; conv_pass=1 -> DONE in the next cycle.
REQ-025 Latency: handshake at edge N -> sample_we high N+1, INIT N+2, en_calc first high N+3.
REQ-026 CALC cycle counter increments each CALC cycle; reaching CALC_TIMEOUT without conv_pass sets timeout_err and moves to CLEAR.
REQ-027 DONE: conv_done=1 for one cycle; data_hptr advances +1, from data_bptr wraps to data_lptr; -> IDLE.
REQ-028 Segment of one address (lptr==bptr): data_hptr stays constant.
REQ-029 flush=1 in any state -> CLEAR next cycle, aborting CALC without conv_done; timeout_err is cleared only by rst.
REQ-030 sample_ready is 0 in every state except IDLE; no back-to-back accept without a full WRITE..DONE pass.

Reset
REQ-031 rst=1 forces state CLEAR; all outputs 0 except ringbuf_addr_clr=1 in the following cycle; timeout_err=0; data_hptr=data_lptr.
REQ-032 rst mid-CALC aborts immediately; no conv_done pulse.

Structure
REQ-033 State encodings and the CALC_TIMEOUT default reside in the shared global macros header.
REQ-034 Head pointer increment/wrap logic is one sub-module, ctrl_seq_hptr (clr, adv, lptr, bptr, hptr).
REQ-035 Counter width = clog2(CALC_TIMEOUT+1).

Verification
REQ-036 Reset then idle: ringbuf_addr_clr pulses once, data_hptr=data_lptr=0x100, sample_ready=1.
REQ-037 sample_valid at N, conv_pass after 8 en_calc cycles -> sample_we N+1, en_init N+2, conv_done N+12, data_hptr 0x100->0x101.
REQ-038 lptr=0x100, bptr=0x103, five samples -> data_hptr sequence 0x101,0x102,0x103,0x100,0x101.
REQ-039 coef_load_req and sample_valid in the same cycle -> coeff_load one cycle, then sample accepted next IDLE cycle.
REQ-040 CALC_TIMEOUT=16, conv_pass held 0 -> timeout_err=1 after 16 en_calc cycles, CLEAR, no conv_done.
REQ-041 flush during CALC -> en_calc drops next cycle, ringbuf_addr_clr pulses, data_hptr=data_lptr.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the convolution control sequencer: state encodings,
// default parameter values and the Moore decode of the RAM-driver controls.
package ctrl_seq_pkg;

    localparam int ADDR_WIDTH_DEFAULT   = 12;
    localparam int CALC_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_INIT  = 3'd4,
        S_CALC  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic sample_we;
        logic en_init;
        logic ringbuf_init;
        logic en_calc;
        logic coeff_load;
        logic ringbuf_addr_clr;
        logic conv_done;
    } ctrl_out_t;

    // Control strobes that are active while the sequencer sits in a given state.
    function automatic ctrl_out_t ctrl_decode(input state_t st);
        ctrl_out_t o;
        o = '0;
        case (st)
            S_CLEAR: o.ringbuf_addr_clr = 1'b1;
            S_LOAD:  o.coeff_load       = 1'b1;
            S_WRITE: o.sample_we        = 1'b1;
            S_INIT: begin
                o.en_init      = 1'b1;
                o.ringbuf_init = 1'b1;
            end
            S_CALC:  o.en_calc          = 1'b1;
            S_DONE:  o.conv_done        = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ctrl_seq_hptr.sv
// Ring-buffer head pointer: reloads to the segment's lower bound on clear and
// steps forward by one on advance, wrapping from the upper bound to the lower.
module ctrl_seq_hptr import ctrl_seq_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  adv,
    input  logic [ADDR_WIDTH-1:0] lptr,
    input  logic [ADDR_WIDTH-1:0] bptr,
    output logic [ADDR_WIDTH-1:0] hptr
);

    // Clear has priority; a one-address segment wraps onto itself and holds.
    always_ff @(posedge clk) begin
        if (clr) begin
            hptr <= lptr;
        end else if (adv) begin
            if (hptr == bptr) begin
                hptr <= lptr;
            end else begin
                hptr <= hptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Convolution control sequencer: accepts one sample at a time, writes it into
// the ring buffer, runs the RAM driver through INIT and CALC, and advances the
// head pointer once the convolution reports completion.
module ctrl_seq import ctrl_seq_pkg::*; #(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
    parameter int CALC_TIMEOUT = CALC_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  coef_load_req,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [ADDR_WIDTH-1:0] data_lptr,
    input  logic [ADDR_WIDTH-1:0] data_bptr,
    input  logic                  conv_pass,
    output logic [ADDR_WIDTH-1:0] data_hptr,
    output logic                  sample_we,
    output logic                  en_init,
    output logic                  ringbuf_init,
    output logic                  en_calc,
    output logic                  coeff_load,
    output logic                  ringbuf_addr_clr,
    output logic                  conv_done,
    output logic                  timeout_err
);

    localparam int               CNT_W    = $clog2(CALC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALC_TIMEOUT - 1);

    state_t           state;
    ctrl_out_t        ctrl;
    logic [CNT_W-1:0] calc_cnt;
    logic             hptr_clr;
    logic             hptr_adv;

    // A sample is taken only when the FSM will really move to WRITE this edge,
    // so a coefficient load, flush or reset in the same cycle refuses it.
    assign sample_ready = (state == S_IDLE) && !coef_load_req && !flush && !rst;

    // Sequencer FSM; the control strobes are registered alongside the state so
    // they switch on the same edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CLEAR;
            ctrl        <= ctrl_decode(S_CLEAR);
            calc_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (flush) begin
            state    <= S_CLEAR;
            ctrl     <= ctrl_decode(S_CLEAR);
            calc_cnt <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    state    <= S_IDLE;
                    ctrl     <= ctrl_decode(S_IDLE);
                    calc_cnt <= '0;
                end
                S_IDLE: begin
                    if (coef_load_req) begin
                        state <= S_LOAD;
                        ctrl  <= ctrl_decode(S_LOAD);
                    end else if (sample_valid) begin
                        state <= S_WRITE;
                        ctrl  <= ctrl_decode(S_WRITE);
                    end else begin
                        state <= S_IDLE;
                        ctrl  <= ctrl_decode(S_IDLE);
                    end
                end
                S_LOAD: begin
                    state <= S_IDLE;
                    ctrl  <= ctrl_decode(S_IDLE);
                end
                S_WRITE: begin
                    state <= S_INIT;
                    ctrl  <= ctrl_decode(S_INIT);
                end
                S_INIT: begin
                    state    <= S_CALC;
                    ctrl     <= ctrl_decode(S_CALC);
                    calc_cnt <= '0;
                end
                S_CALC: begin
                    if (conv_pass) begin
                        state <= S_DONE;
                        ctrl  <= ctrl_decode(S_DONE);
                    end else if (calc_cnt == CNT_LAST) begin
                        state       <= S_CLEAR;
                        ctrl        <= ctrl_decode(S_CLEAR);
                        calc_cnt    <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        state    <= S_CALC;
                        ctrl     <= ctrl_decode(S_CALC);
                        calc_cnt <= calc_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ctrl  <= ctrl_decode(S_IDLE);
                end
                default: begin
                    state <= S_CLEAR;
                    ctrl  <= ctrl_decode(S_CLEAR);
                end
            endcase
        end
    end

    // Reset reloads the head pointer on the reset edge itself; CLEAR reloads it
    // on leaving, and DONE steps it once per finished convolution.
    assign hptr_clr = rst || (state == S_CLEAR);
    assign hptr_adv = (state == S_DONE);

    ctrl_seq_hptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hptr (
        .clk  (clk),
        .clr  (hptr_clr),
        .adv  (hptr_adv),
        .lptr (data_lptr),
        .bptr (data_bptr),
        .hptr (data_hptr)
    );

    assign sample_we        = ctrl.sample_we;
    assign en_init          = ctrl.en_init;
    assign ringbuf_init     = ctrl.ringbuf_init;
    assign en_calc          = ctrl.en_calc;
    assign coeff_load       = ctrl.coeff_load;
    assign ringbuf_addr_clr = ctrl.ringbuf_addr_clr;
    assign conv_done        = ctrl.conv_done;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: latency schedule, head-pointer wrap,
// load priority, back-to-back samples, CALC timeout, flush and reset aborts.
module tb_ctrl_seq;

    localparam int AW = 12;
    localparam int TO = 16;

    // Observed strobe vector bit order:
    // {sample_we, en_init, ringbuf_init, en_calc, coeff_load, ringbuf_addr_clr, conv_done, sample_ready}
    localparam logic [7:0] V_WE   = 8'b1000_0000;
    localparam logic [7:0] V_INIT = 8'b0110_0000;
    localparam logic [7:0] V_CALC = 8'b0001_0000;
    localparam logic [7:0] V_LOAD = 8'b0000_1000;
    localparam logic [7:0] V_CLR  = 8'b0000_0100;
    localparam logic [7:0] V_DONE = 8'b0000_0010;
    localparam logic [7:0] V_IDLE = 8'b0000_0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          coef_load_req = 1'b0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [AW-1:0] data_lptr = 12'h100;
    logic [AW-1:0] data_bptr = 12'h103;
    logic          conv_pass = 1'b0;
    logic [AW-1:0] data_hptr;
    logic          sample_we;
    logic          en_init;
    logic          ringbuf_init;
    logic          en_calc;
    logic          coeff_load;
    logic          ringbuf_addr_clr;
    logic          conv_done;
    logic          timeout_err;

    logic [7:0]    obs;
    int            checks = 0;
    int            fails  = 0;
    logic [AW-1:0] sb_q[$];
    logic [AW-1:0] wrap_tab [5] = '{12'h101, 12'h102, 12'h103, 12'h100, 12'h101};

    assign obs = {sample_we, en_init, ringbuf_init, en_calc,
                  coeff_load, ringbuf_addr_clr, conv_done, sample_ready};

    ctrl_seq #(
        .ADDR_WIDTH   (AW),
        .CALC_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .coef_load_req    (coef_load_req),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .data_lptr        (data_lptr),
        .data_bptr        (data_bptr),
        .conv_pass        (conv_pass),
        .data_hptr        (data_hptr),
        .sample_we        (sample_we),
        .en_init          (en_init),
        .ringbuf_init     (ringbuf_init),
        .en_calc          (en_calc),
        .coeff_load       (coeff_load),
        .ringbuf_addr_clr (ringbuf_addr_clr),
        .conv_done        (conv_done),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    // Hold reset for two edges, release, and land in IDLE one cycle later.
    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        coef_load_req = 1'b0;
        conv_pass = 1'b0;
        flush = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Present one sample in IDLE and step past the accepting edge.
    task automatic start_sample();
        sample_valid = 1'b1;
        #1;
        checks++;
        if (sample_ready !== 1'b1)
            begin fails++; $display("[TB] FAIL start_ready: got %b expected 1", sample_ready); end
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    // One full sample pass with conv_pass raised after k en_calc cycles; the
    // expected head pointer goes to the scoreboard when the sample is offered
    // and is retired the cycle after conv_done is seen.
    task automatic run_transaction(input int k, input logic [AW-1:0] exp_hptr, input bit hold_valid);
        int         guard;
        logic [7:0] exp;
        bit         done_prev;
        logic [AW-1:0] want;
        guard = 0;
        done_prev = 1'b0;
        while (sample_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (sample_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ready_wait: got %b expected 1 within 50 cycles", sample_ready);
            return;
        end
        sample_valid = 1'b1;
        sb_q.push_back(exp_hptr);
        @(posedge clk); #1;
        if (!hold_valid) sample_valid = 1'b0;
        for (int cyc = 1; cyc <= k + 5; cyc++) begin
            if (cyc == 1)           exp = V_WE;
            else if (cyc == 2)      exp = V_INIT;
            else if (cyc <= k + 3)  exp = V_CALC;
            else if (cyc == k + 4)  exp = V_DONE;
            else                    exp = V_IDLE;
            checks++;
            if (obs !== exp)
                begin fails++; $display("[TB] FAIL strobes cyc%0d: got %b expected %b", cyc, obs, exp); end
            if (done_prev) begin
                checks++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL scoreboard_empty: got conv_done with no pending sample, expected one");
                end else begin
                    want = sb_q.pop_front();
                    if (data_hptr !== want)
                        begin fails++; $display("[TB] FAIL hptr_after_done: got %h expected %h", data_hptr, want); end
                end
            end
            done_prev = (conv_done === 1'b1);
            conv_pass = (cyc == k + 3);
            if (cyc < k + 5) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_left: got %0d pending entries expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Reset state: only ringbuf_addr_clr, pointer at lower bound, then a single clear pulse.
    task automatic test_reset();
        int clr_cnt;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (obs !== V_CLR)
            begin fails++; $display("[TB] FAIL reset_strobes: got %b expected %b", obs, V_CLR); end
        checks++;
        if (data_hptr !== 12'h100)
            begin fails++; $display("[TB] FAIL reset_hptr: got %h expected 100", data_hptr); end
        checks++;
        if (timeout_err !== 1'b0)
            begin fails++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        rst = 1'b0;
        clr_cnt = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ringbuf_addr_clr === 1'b1) clr_cnt++;
        end
        checks++;
        if (clr_cnt != 1)
            begin fails++; $display("[TB] FAIL clr_pulse_count: got %0d expected 1", clr_cnt); end
        checks++;
        if (obs !== V_IDLE)
            begin fails++; $display("[TB] FAIL idle_strobes: got %b expected %b", obs, V_IDLE); end
        checks++;
        if (data_hptr !== 12'h100)
            begin fails++; $display("[TB] FAIL idle_hptr: got %h expected 100", data_hptr); end
    endtask

    // Nominal latency: WRITE, INIT, CALC and conv_done twelve cycles after the accept.
    task automatic test_single_sample();
        run_transaction(8, 12'h101, 1'b0);
    endtask

    // Load request beats a simultaneous sample; the sample goes in afterwards.
    task automatic test_load_priority();
        do_reset();
        coef_load_req = 1'b1;
        sample_valid = 1'b1;
        #1;
        checks++;
        if (sample_ready !== 1'b0)
            begin fails++; $display("[TB] FAIL load_ready_low: got %b expected 0", sample_ready); end
        @(posedge clk); #1;
        coef_load_req = 1'b0;
        checks++;
        if (obs !== V_LOAD)
            begin fails++; $display("[TB] FAIL load_strobes: got %b expected %b", obs, V_LOAD); end
        @(posedge clk); #1;
        checks++;
        if (obs !== V_IDLE)
            begin fails++; $display("[TB] FAIL load_return_idle: got %b expected %b", obs, V_IDLE); end
        run_transaction(8, 12'h101, 1'b0);
    endtask

    // Valid held high: the second accept waits for a complete pass.
    task automatic test_back_to_back();
        run_transaction(8, 12'h102, 1'b1);
        run_transaction(8, 12'h103, 1'b1);
        sample_valid = 1'b0;
    endtask

    // Four-address segment, five samples, wraps from 0x103 back to 0x100.
    task automatic test_wrap();
        data_lptr = 12'h100;
        data_bptr = 12'h103;
        do_reset();
        for (int i = 0; i < 5; i++) run_transaction(8, wrap_tab[i], 1'b0);
    endtask

    // One-address segment: the head pointer never moves.
    task automatic test_single_address();
        data_lptr = 12'h200;
        data_bptr = 12'h200;
        do_reset();
        checks++;
        if (data_hptr !== 12'h200)
            begin fails++; $display("[TB] FAIL single_addr_reset: got %h expected 200", data_hptr); end
        run_transaction(4, 12'h200, 1'b0);
        run_transaction(8, 12'h200, 1'b0);
        data_lptr = 12'h100;
        data_bptr = 12'h103;
    endtask

    // No conv_pass: abort after 16 en_calc cycles into CLEAR, sticky error, no conv_done.
    task automatic test_timeout();
        logic [7:0] exp;
        int         calc_cnt;
        do_reset();
        run_transaction(8, 12'h101, 1'b0);
        calc_cnt = 0;
        start_sample();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 1)       exp = V_WE;
            else if (cyc == 2)  exp = V_INIT;
            else if (cyc <= 18) exp = V_CALC;
            else if (cyc == 19) exp = V_CLR;
            else                exp = V_IDLE;
            if (en_calc === 1'b1) calc_cnt++;
            checks++;
            if (obs !== exp)
                begin fails++; $display("[TB] FAIL timeout_strobes cyc%0d: got %b expected %b", cyc, obs, exp); end
            checks++;
            if (timeout_err !== (cyc >= 19))
                begin fails++; $display("[TB] FAIL timeout_err cyc%0d: got %b expected %b", cyc, timeout_err, cyc >= 19); end
            if (cyc < 20) begin @(posedge clk); #1; end
        end
        checks++;
        if (calc_cnt != TO)
            begin fails++; $display("[TB] FAIL timeout_calc_cycles: got %0d expected %0d", calc_cnt, TO); end
        checks++;
        if (data_hptr !== 12'h100)
            begin fails++; $display("[TB] FAIL timeout_hptr: got %h expected 100", data_hptr); end
    endtask

    // Flush in CALC: en_calc drops, clear pulses, pointer reloads, error stays set.
    task automatic test_flush();
        logic [7:0] exp;
        run_transaction(8, 12'h101, 1'b0);
        start_sample();
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (cyc == 1)      exp = V_WE;
            else if (cyc == 2) exp = V_INIT;
            else if (cyc <= 4) exp = V_CALC;
            else if (cyc == 5) exp = V_CLR;
            else               exp = V_IDLE;
            checks++;
            if (obs !== exp)
                begin fails++; $display("[TB] FAIL flush_strobes cyc%0d: got %b expected %b", cyc, obs, exp); end
            flush = (cyc == 4);
            if (cyc < 7) begin @(posedge clk); #1; end
        end
        checks++;
        if (data_hptr !== 12'h100)
            begin fails++; $display("[TB] FAIL flush_hptr: got %h expected 100", data_hptr); end
        checks++;
        if (timeout_err !== 1'b1)
            begin fails++; $display("[TB] FAIL flush_keeps_err: got %b expected 1", timeout_err); end
    endtask

    // Reset in CALC: immediate abort, no conv_done, error cleared, pointer reloaded.
    task automatic test_reset_mid_calc();
        logic [7:0] exp;
        run_transaction(8, 12'h101, 1'b0);
        start_sample();
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (cyc == 1)      exp = V_WE;
            else if (cyc == 2) exp = V_INIT;
            else if (cyc <= 4) exp = V_CALC;
            else if (cyc == 5) exp = V_CLR;
            else               exp = V_IDLE;
            checks++;
            if (obs !== exp)
                begin fails++; $display("[TB] FAIL rst_calc_strobes cyc%0d: got %b expected %b", cyc, obs, exp); end
            if (cyc == 5) begin
                checks++;
                if (timeout_err !== 1'b0)
                    begin fails++; $display("[TB] FAIL rst_clears_err: got %b expected 0", timeout_err); end
                checks++;
                if (data_hptr !== 12'h100)
                    begin fails++; $display("[TB] FAIL rst_calc_hptr: got %h expected 100", data_hptr); end
            end
            rst = (cyc == 4);
            if (cyc < 7) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_load_priority();
        test_back_to_back();
        test_wrap();
        test_single_address();
        test_timeout();
        test_flush();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation time limit expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
